// File: rtl/srl_uart_responder_pkg.sv
// Shared definitions for the serial window responder at $9F60-$9F6F.
// Register indices, STAT/CTRL bit positions, the UART FSM state type and the
// baud divisor clamp. The monitor ROM build and the bench use the same numbers.
`timescale 1ns/1ps
package srl_uart_responder_pkg;

  localparam logic [3:0] REG_DATA  = 4'd0;
  localparam logic [3:0] REG_STAT  = 4'd1;
  localparam logic [3:0] REG_CTRL  = 4'd2;
  localparam logic [3:0] REG_DIVLO = 4'd3;
  localparam logic [3:0] REG_DIVHI = 4'd4;

  localparam int STAT_RXAVAIL  = 0;
  localparam int STAT_THREMPTY = 1;
  localparam int STAT_TXIDLE   = 2;
  localparam int STAT_OVERRUN  = 3;
  localparam int STAT_FRAMING  = 4;
  localparam int STAT_IRQ      = 7;

  localparam int CTRL_RXIE   = 0;
  localparam int CTRL_TXIE   = 1;
  localparam int CTRL_LOOP   = 2;
  localparam int CTRL_CLRERR = 7;

  localparam logic [15:0] DIV_MIN = 16'd16;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uartState_t;

  // Very small divisors would make the half-bit point meaningless.
  function automatic logic [15:0] clampDiv(input logic [15:0] d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

endpackage

// File: rtl/srl_uart_responder_timer.sv
// uart_bit_timer: free-running, loadable 16-bit down-counter.
//   clk, rst  : clock, async active-high reset
//   start     : restart a full bit period now (counter loads div-1)
//   div       : bit period in clk cycles, already clamped (>= 16)
//   tick      : high for the last clk of each bit period
//   halfTick  : high div/2 clks after the period began
// The period is re-latched at every reload, so a new divisor only takes
// effect at a bit boundary.
`timescale 1ns/1ps
module uart_bit_timer
  import srl_uart_responder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] div,
  output logic        tick,
  output logic        halfTick
);

  logic [15:0] cnt;
  logic [15:0] per;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 16'd0;
      per <= DIV_MIN;
    end else if (start || cnt == 16'd0) begin
      cnt <= div - 16'd1;
      per <= div;
    end else begin
      cnt <= cnt - 16'd1;
    end
  end

  assign tick     = (cnt == 16'd0);
  assign halfTick = (cnt == (per - 16'd1 - (per >> 1)));

endmodule

// File: rtl/srl_uart_responder.sv
// srl_uart_responder: 6502 bus responder for the serial window, 8N1 UART.
//   clk/rst       : 16 MHz clock, async active-high reset
//   sysClk        : CPU phi2 (synchronous to clk)
//   srlEn         : active-low chip select; rw: 1 = read
//   adrLo         : register index; datIn/datOut/datOe: data bus
//   txd/rxd       : serial lines; irqN: active-low interrupt
// Holds a 1-byte THR, a small RX FIFO, status/IRQ logic and the baud divisor.
`timescale 1ns/1ps
module srl_uart_responder
  import srl_uart_responder_pkg::*;
#(
  parameter logic [15:0] DIV_RESET = 16'd138,
  parameter int          RX_DEPTH  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sysClk,
  input  logic       srlEn,
  input  logic       rw,
  input  logic [3:0] adrLo,
  input  logic [7:0] datIn,
  output logic [7:0] datOut,
  output logic       datOe,
  output logic       txd,
  input  logic       rxd,
  output logic       irqN
);

  localparam int          PW        = $clog2(RX_DEPTH);
  localparam logic [PW:0] FIFO_FULL = (PW + 1)'(RX_DEPTH);

  logic phiQ, commit, wrStb, rdStb, clrErr;
  logic [2:0]  ctrl;
  logic [15:0] divReg, divEff;
  logic [7:0]  thr, txShift, rxShift, lastHead, rxHead, stat;
  logic        thrFull, overrun, framing;
  logic [2:0]  txBitCnt, rxBitCnt;
  uartState_t  txState, txNext, rxState, rxNext;
  logic        txStart, txTick, txHalfUnused, txSer;
  logic        rxStart, rxTick, rxHalf, rxSrc, rxS1, rxS2, rxPrev;
  logic        pushReq, frameErr, push, pop, ovfl;
  logic [7:0]  rxFifo [RX_DEPTH];
  logic [PW-1:0] wrPtr, rdPtr;
  logic [PW:0]   count;

  // Commit point: the clk edge where phi2 has just fallen with the chip selected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) phiQ <= 1'b0;
    else     phiQ <= sysClk;
  end

  assign commit = phiQ & ~sysClk & ~srlEn;
  assign wrStb  = commit & ~rw;
  assign rdStb  = commit & rw;
  assign clrErr = wrStb && (adrLo == REG_CTRL) && datIn[CTRL_CLRERR];
  assign divEff = clampDiv(divReg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl   <= 3'b000;
      divReg <= DIV_RESET;
    end else if (wrStb) begin
      case (adrLo)
        REG_CTRL:  ctrl          <= datIn[2:0];
        REG_DIVLO: divReg[7:0]   <= datIn;
        REG_DIVHI: divReg[15:8]  <= datIn;
        default:   ;
      endcase
    end
  end

  uart_bit_timer uTxTimer (
    .clk(clk), .rst(rst), .start(txStart), .div(divEff),
    .tick(txTick), .halfTick(txHalfUnused)
  );

  uart_bit_timer uRxTimer (
    .clk(clk), .rst(rst), .start(rxStart), .div(divEff),
    .tick(rxTick), .halfTick(rxHalf)
  );

  // TX FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) txState <= UART_IDLE;
    else     txState <= txNext;
  end

  always_comb begin
    txNext  = txState;
    txStart = 1'b0;
    case (txState)
      UART_IDLE:  if (thrFull) begin txNext = UART_START; txStart = 1'b1; end
      UART_START: if (txTick) txNext = UART_DATA;
      UART_DATA:  if (txTick && txBitCnt == 3'd7) txNext = UART_STOP;
      UART_STOP:  if (txTick) txNext = UART_IDLE;
      default:    txNext = UART_IDLE;
    endcase
  end

  // The THR load and a DATA write can never coincide: writes are dropped while full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      thrFull  <= 1'b0;
      txBitCnt <= 3'd0;
    end else begin
      if (txState == UART_IDLE && thrFull) begin
        thrFull  <= 1'b0;
        txBitCnt <= 3'd0;
      end else if (txState == UART_DATA && txTick) begin
        txBitCnt <= txBitCnt + 3'd1;
      end
      if (wrStb && adrLo == REG_DATA && !thrFull) thrFull <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wrStb && adrLo == REG_DATA && !thrFull) thr <= datIn;
    if (txState == UART_IDLE && thrFull) txShift <= thr;
    else if (txState == UART_DATA && txTick) txShift <= {1'b0, txShift[7:1]};
  end

  // Derived from registered state only, so reset forces the line high at once.
  assign txSer = (txState == UART_START) ? 1'b0 :
                 (txState == UART_DATA)  ? txShift[0] : 1'b1;
  assign txd   = ctrl[CTRL_LOOP] ? 1'b1 : txSer;

  // RX input: select source, then synchronise; rxPrev gives the falling-edge
  // detect so a held-low line after a framing error does not restart a frame.
  assign rxSrc = ctrl[CTRL_LOOP] ? txSer : rxd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxS1   <= 1'b1;
      rxS2   <= 1'b1;
      rxPrev <= 1'b1;
    end else begin
      rxS1   <= rxSrc;
      rxS2   <= rxS1;
      rxPrev <= rxS2;
    end
  end

  // RX FSM; restarting the timer at the start midpoint aligns later ticks to bit centres.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rxState <= UART_IDLE;
    else     rxState <= rxNext;
  end

  always_comb begin
    rxNext   = rxState;
    rxStart  = 1'b0;
    pushReq  = 1'b0;
    frameErr = 1'b0;
    case (rxState)
      UART_IDLE: if (!rxS2 && rxPrev) begin rxNext = UART_START; rxStart = 1'b1; end
      UART_START:
        if (rxHalf) begin
          if (rxS2) rxNext = UART_IDLE;
          else begin rxNext = UART_DATA; rxStart = 1'b1; end
        end
      UART_DATA: if (rxTick && rxBitCnt == 3'd7) rxNext = UART_STOP;
      UART_STOP:
        if (rxTick) begin
          rxNext = UART_IDLE;
          if (!rxS2) frameErr = 1'b1;
          else       pushReq  = 1'b1;
        end
      default: rxNext = UART_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rxBitCnt <= 3'd0;
    else if (rxState == UART_START) rxBitCnt <= 3'd0;
    else if (rxState == UART_DATA && rxTick) rxBitCnt <= rxBitCnt + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (rxState == UART_DATA && rxTick) rxShift <= {rxS2, rxShift[7:1]};
  end

  // RX FIFO
  assign pop  = rdStb && (adrLo == REG_DATA) && (count != '0);
  assign push = pushReq && ((count != FIFO_FULL) || pop);
  assign ovfl = pushReq && (count == FIFO_FULL) && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) rxFifo[wrPtr] <= rxShift;
    if (pop)  lastHead      <= rxFifo[rdPtr];
  end

  assign rxHead = (count != '0) ? rxFifo[rdPtr] : lastHead;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
      framing <= 1'b0;
    end else begin
      if (clrErr) begin
        overrun <= 1'b0;
        framing <= 1'b0;
      end
      if (ovfl)     overrun <= 1'b1;
      if (frameErr) framing <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) irqN <= 1'b1;
    else     irqN <= ~((ctrl[CTRL_RXIE] & (count != '0)) | (ctrl[CTRL_TXIE] & ~thrFull));
  end

  always_comb begin
    stat                = 8'h00;
    stat[STAT_RXAVAIL]  = (count != '0);
    stat[STAT_THREMPTY] = ~thrFull;
    stat[STAT_TXIDLE]   = (txState == UART_IDLE);
    stat[STAT_OVERRUN]  = overrun;
    stat[STAT_FRAMING]  = framing;
    stat[STAT_IRQ]      = ~irqN;
  end

  always_comb begin
    datOut = 8'h00;
    case (adrLo)
      REG_DATA:  datOut = rxHead;
      REG_STAT:  datOut = stat;
      REG_CTRL:  datOut = {5'b00000, ctrl};
      REG_DIVLO: datOut = divReg[7:0];
      REG_DIVHI: datOut = divReg[15:8];
      default:   datOut = 8'h00;
    endcase
  end

  assign datOe = ~srlEn & rw & sysClk;

endmodule
